// File: rtl/tournament_select_if.sv
// Fetch/resolve handshake bundle between the branch pipeline and the tournament
// chooser select unit.
interface tournament_select_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             fetch_valid;
  logic             fetch_ready;
  logic [31:0]      fetch_pc;
  logic             local_pred;
  logic             global_pred;
  logic             pred_taken;
  logic             pred_sel;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic             resolve_err;
  logic [CNT_W-1:0] inflight_cnt;

  modport master (
    output fetch_valid, fetch_pc, local_pred, global_pred,
           resolve_valid, resolve_taken, flush,
    input  fetch_ready, pred_taken, pred_sel, resolve_err, inflight_cnt
  );

  modport slave (
    input  fetch_valid, fetch_pc, local_pred, global_pred,
           resolve_valid, resolve_taken, flush,
    output fetch_ready, pred_taken, pred_sel, resolve_err, inflight_cnt
  );
endinterface

// File: rtl/tournament_select_unit.sv
// Tournament predictor chooser: 0-latency table read at fetch, in-order FIFO of
// in-flight predictions, saturating chooser update written back at resolve.
module tournament_select_unit #(
  parameter int IDX_W = 5,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  tournament_select_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int PTR_W   = AW + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             local_pred;
    logic             global_pred;
  } entry_t;

  logic [1:0]       chooser_q [ENTRIES];
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             resolve_err_q;

  logic [IDX_W-1:0] fetch_idx;
  logic [PTR_W-1:0] count;
  logic             empty, full, pop_en, push_en, lok, gok;
  entry_t           head, push_entry;
  logic [1:0]       upd_val, read_val;
  logic             unused_pc_bits;

  assign fetch_idx      = bus.fetch_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.fetch_pc[31:IDX_W+2], bus.fetch_pc[1:0]};

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == PTR_W'(DEPTH));
  assign head    = fifo_q[rd_ptr_q[AW-1:0]];
  assign pop_en  = bus.resolve_valid && !empty;
  assign push_en = bus.fetch_valid && !full && !bus.flush;

  assign lok = (head.local_pred  == bus.resolve_taken);
  assign gok = (head.global_pred == bus.resolve_taken);

  // NOTE: every always_comb output gets a default assignment first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    upd_val = chooser_q[head.idx];
    if (lok && !gok && upd_val != 2'b00)      upd_val = upd_val - 2'd1;
    else if (gok && !lok && upd_val != 2'b11) upd_val = upd_val + 2'd1;
  end

  // Write-first: a fetch reading the entry being updated sees the new value.
  assign read_val = (pop_en && head.idx == fetch_idx) ? upd_val : chooser_q[fetch_idx];

  assign push_entry = '{idx: fetch_idx, local_pred: bus.local_pred,
                        global_pred: bus.global_pred};

  assign bus.pred_sel     = read_val[1];
  assign bus.pred_taken   = read_val[1] ? bus.global_pred : bus.local_pred;
  assign bus.fetch_ready  = !full;
  assign bus.inflight_cnt = count;
  assign bus.resolve_err  = resolve_err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      resolve_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      resolve_err_q <= bus.resolve_valid && empty;
    end
  end

  // NOTE: the chooser table must come out of reset as weak-local, so it is built
  // from resettable flops; the FIFO payload is only read behind a valid pointer
  // and is deliberately left without reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) chooser_q[i] <= 2'b01;
    end else if (pop_en) begin
      chooser_q[head.idx] <= upd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) fifo_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end
endmodule

// File: tb/tb_tournament_select_unit.sv
// Self-checking bench for tournament_select_unit: directed vector table, reset
// sequences and randomized traffic against a queue/array reference model.
`timescale 1ns/1ps
module tb_tournament_select_unit;
  localparam int DEPTH = 4;
  localparam int NIDX  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tournament_select_if #(.DEPTH(DEPTH)) bus ();

  tournament_select_unit #(.IDX_W(5), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          fv;
    logic [31:0] pc;
    bit          lp, gp, rv, rt, fl;
    bit          chk;
    bit          esel, etaken, eready;
    int          ecnt;
    bit          eerr;
  } vec_t;

  typedef struct {
    int idx;
    bit lp;
    bit gp;
  } ment_t;

  int    mtbl [NIDX];
  ment_t mq[$];
  bit    merr;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  vec_t  vecs [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic int chooser_next(int v, bit l, bit g, bit t);
    bit lok = (l == t);
    bit gok = (g == t);
    if (lok && !gok) return (v > 0) ? v - 1 : 0;
    if (gok && !lok) return (v < 3) ? v + 1 : 3;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NIDX; i++) mtbl[i] = 1;
    mq.delete();
    merr = 1'b0;
  endtask

  // Entered at posedge+1; drives one cycle of inputs, checks at negedge.
  task automatic step(input vec_t v, input bit use_vec);
    int pre_size, eff, new_val, idx;
    bit do_pop;
    bus.fetch_valid   = v.fv;
    bus.fetch_pc      = v.pc;
    bus.local_pred    = v.lp;
    bus.global_pred   = v.gp;
    bus.resolve_valid = v.rv;
    bus.resolve_taken = v.rt;
    bus.flush         = v.fl;
    @(negedge clk);
    pre_size = mq.size();
    do_pop   = v.rv && pre_size > 0;
    new_val  = do_pop ? chooser_next(mtbl[mq[0].idx], mq[0].lp, mq[0].gp, v.rt) : 0;
    idx      = int'(v.pc[6:2]);
    eff      = (do_pop && mq[0].idx == idx) ? new_val : mtbl[idx];
    if (v.fv) begin
      check("pred_sel", 32'(bus.pred_sel), 32'(eff >= 2));
      check("pred_taken", 32'(bus.pred_taken), 32'((eff >= 2) ? v.gp : v.lp));
    end
    check("fetch_ready", 32'(bus.fetch_ready), 32'(pre_size != DEPTH));
    check("inflight_cnt", 32'(bus.inflight_cnt), 32'(pre_size));
    check("resolve_err", 32'(bus.resolve_err), 32'(merr));
    if (use_vec) begin
      if (v.chk) begin
        check("vec_pred_sel", 32'(bus.pred_sel), 32'(v.esel));
        check("vec_pred_taken", 32'(bus.pred_taken), 32'(v.etaken));
      end
      check("vec_fetch_ready", 32'(bus.fetch_ready), 32'(v.eready));
      check("vec_inflight_cnt", 32'(bus.inflight_cnt), 32'(v.ecnt));
      check("vec_resolve_err", 32'(bus.resolve_err), 32'(v.eerr));
    end
    @(posedge clk);
    merr = v.rv && pre_size == 0;
    if (do_pop) begin
      mtbl[mq[0].idx] = new_val;
      void'(mq.pop_front());
    end
    if (v.fl) mq.delete();
    else if (v.fv && pre_size != DEPTH) mq.push_back('{idx: idx, lp: v.lp, gp: v.gp});
    #1;
  endtask

  // While reset is held, every table entry must read as a local choice.
  task automatic sweep_reset_table();
    bus.fetch_valid = 1'b1;
    bus.local_pred  = 1'b1;
    bus.global_pred = 1'b0;
    for (int i = 0; i < NIDX; i++) begin
      bus.fetch_pc = 32'(i) << 2;
      #0.25;
      check("reset_pred_sel", 32'(bus.pred_sel), 32'd0);
    end
    check("reset_pred_taken", 32'(bus.pred_taken), 32'd1);
    check("reset_inflight_cnt", 32'(bus.inflight_cnt), 32'd0);
    check("reset_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    check("reset_resolve_err", 32'(bus.resolve_err), 32'd0);
  endtask

  task automatic idle_inputs();
    bus.fetch_valid   = 1'b0;
    bus.fetch_pc      = '0;
    bus.local_pred    = 1'b0;
    bus.global_pred   = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.flush         = 1'b0;
  endtask

  initial begin
    vec_t  rv_vec;
    logic [31:0] r;
    //          fv pc        lp gp rv rt fl chk sel tkn rdy cnt err
    vecs[0]  = '{1, 32'h40, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    vecs[1]  = '{0, 32'h00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0};
    vecs[2]  = '{1, 32'h40, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    vecs[3]  = '{1, 32'h40, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    vecs[4]  = '{1, 32'h40, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    vecs[5]  = '{0, 32'h00, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
    vecs[6]  = '{1, 32'h40, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    vecs[7]  = '{1, 32'h80, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
    vecs[8]  = '{1, 32'h80, 1, 0, 0, 0, 0, 1, 0, 1, 1, 2, 0};
    vecs[9]  = '{1, 32'h80, 1, 0, 0, 0, 0, 1, 0, 1, 1, 3, 0};
    vecs[10] = '{1, 32'h80, 1, 0, 1, 1, 0, 1, 0, 1, 0, 4, 0};
    vecs[11] = '{0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0};
    vecs[12] = '{0, 32'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0};
    vecs[13] = '{0, 32'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0};
    vecs[14] = '{0, 32'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[15] = '{1, 32'h80, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    vecs[16] = '{0, 32'h00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0};
    vecs[17] = '{1, 32'h48, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    vecs[18] = '{1, 32'h44, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
    vecs[19] = '{1, 32'h48, 1, 0, 1, 1, 1, 1, 0, 1, 1, 2, 0};
    vecs[20] = '{0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[21] = '{1, 32'h48, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    vecs[22] = '{0, 32'h00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0};
    vecs[23] = '{0, 32'h00, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[24] = '{0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[25] = '{1, 32'h48, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};

    idle_inputs();
    model_reset();
    #12;
    sweep_reset_table();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i], 1'b1);

    // Mid-stream async reset: entries 0 and 16 are global-leaning and two are in flight.
    step('{1, 32'h80, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0}, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(bus.inflight_cnt), 32'd0);
    sweep_reset_table();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      rv_vec.fv  = ($urandom_range(0, 9) < 6);
      rv_vec.pc  = {r[31:7], 5'($urandom_range(0, 7)), 2'b00};
      rv_vec.lp  = 1'($urandom);
      rv_vec.gp  = 1'($urandom);
      rv_vec.rv  = ($urandom_range(0, 9) < 5);
      rv_vec.rt  = 1'($urandom);
      rv_vec.fl  = ($urandom_range(0, 19) == 0);
      rv_vec.chk = 1'b0;
      rv_vec.esel = 1'b0;
      rv_vec.etaken = 1'b0;
      rv_vec.eready = 1'b0;
      rv_vec.ecnt = 0;
      rv_vec.eerr = 1'b0;
      step(rv_vec, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
